// File: rtl/parchk_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parchk_pkg : FSM encoding and frame constants shared by parchk   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package parchk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   ERRCNT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/parchk_errcnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parchk_errcnt : saturating count of frames flagged with an error |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module parchk_errcnt
  import parchk_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  output logic [ERRCNT_W-1:0] cnt_o
);

  logic [ERRCNT_W-1:0] cnt_q;
  logic [ERRCNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {ERRCNT_W{1'b1}})) begin
      cnt_d = cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/parchk.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parchk : serial start/data/parity/stop frame checker; define     |
// | PARCHK_ERRCNT_EN to add the err_cnt output.   Rev 1.0            |
// +------------------------------------------------------------------+
module parchk
  import parchk_pkg::*;
#(
  parameter int DATA_W  = 3,
  parameter int ODD_PAR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy
`ifdef PARCHK_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  localparam int   CNT_W   = $clog2(DATA_W + 1);
  localparam logic ODD_BIT = (ODD_PAR != 0);

  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [DATA_W-1:0]   shreg_q,   shreg_d;
  logic                acc_q,     acc_d;
  logic                mis_q,     mis_d;
  logic [DATA_W-1:0]   dout_q,    dout_d;
  logic                dvalid_q,  dvalid_d;
  logic                par_err_q, par_err_d;
  logic                frm_err_q, frm_err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    mis_d     = mis_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (sin == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
          end
        end
        DATA: begin
          // LSB arrives first, so shifting right into the MSB leaves it at bit 0.
          shreg_d         = shreg_q >> 1;
          shreg_d[DATA_W-1] = sin;
          acc_d           = acc_q ^ sin;
          cnt_d           = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PAR;
          end
        end
        PAR: begin
          mis_d   = acc_q ^ sin ^ ODD_BIT;
          state_d = STOP;
        end
        STOP: begin
          dout_d    = shreg_q;
          dvalid_d  = 1'b1;
          par_err_d = mis_q;
          frm_err_d = (sin != STOP_BIT);
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      acc_q     <= 1'b0;
      mis_q     <= 1'b0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      acc_q     <= acc_d;
      mis_q     <= mis_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign dout    = dout_q;
  assign dvalid  = dvalid_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign busy    = (state_q != IDLE);

`ifdef PARCHK_ERRCNT_EN
  // Fed from the next-state terms so err_cnt moves on the same edge as dvalid.
  logic err_inc;
  assign err_inc = dvalid_d & (par_err_d | frm_err_d);

  parchk_errcnt u_errcnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (err_inc),
    .cnt_o (err_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_parchk.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_parchk : self-checking bench for parchk (even and odd sense)  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_parchk;

  localparam int DW = 3;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          bit_en = 1'b0;
  logic          sin    = 1'b1;
  logic [DW-1:0] dout_e, dout_o;
  logic          dv_e, pe_e, fe_e, bz_e;
  logic          dv_o, pe_o, fe_o, bz_o;
`ifdef PARCHK_ERRCNT_EN
  logic [7:0]    ec_e, ec_o;
`endif

  always #5 clk = ~clk;

  parchk #(.DATA_W(DW), .ODD_PAR(0)) u_even (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin),
    .dout(dout_e), .dvalid(dv_e), .par_err(pe_e), .frm_err(fe_e), .busy(bz_e)
`ifdef PARCHK_ERRCNT_EN
    , .err_cnt(ec_e)
`endif
  );

  parchk #(.DATA_W(DW), .ODD_PAR(1)) u_odd (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin),
    .dout(dout_o), .dvalid(dv_o), .par_err(pe_o), .frm_err(fe_o), .busy(bz_o)
`ifdef PARCHK_ERRCNT_EN
    , .err_cnt(ec_o)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: collects the bits of a frame and judges it as a whole.
  logic          frame_q[$];
  logic          m_busy = 1'b0;
  logic          m_dv   = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic          m_pe_even = 1'b0;
  logic          m_fe      = 1'b0;
  int            m_ec      = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          pbit;
    logic          stop;
    logic [DW-1:0] exp_dout;
    logic          exp_pe;
    logic          exp_fe;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic en, input logic s, input logic r);
    if (r) begin
      frame_q.delete();
      m_busy = 1'b0;
      m_dv   = 1'b0;
      m_dout = '0;
      m_ec   = 0;
    end else begin
      m_dv = 1'b0;
      if (en) begin
        if (!m_busy) begin
          if (s == 1'b0) begin
            m_busy = 1'b1;
            frame_q.delete();
          end
        end else begin
          frame_q.push_back(s);
          if (frame_q.size() == DW + 2) begin
            int data = 0;
            int ones = 0;
            for (int i = 0; i < DW; i++) begin
              data += int'(frame_q[i]) << i;
              ones += int'(frame_q[i]);
            end
            ones     += int'(frame_q[DW]);
            m_dout    = DW'(data);
            m_pe_even = (ones % 2) != 0;
            m_fe      = (frame_q[DW+1] == 1'b0);
            m_dv      = 1'b1;
            m_busy    = 1'b0;
            if ((m_pe_even || m_fe) && m_ec < 255) m_ec++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("busy_even", 32'(bz_e), 32'(m_busy));
    chk("busy_odd", 32'(bz_o), 32'(m_busy));
    chk("dvalid_even", 32'(dv_e), 32'(m_dv));
    chk("dvalid_odd", 32'(dv_o), 32'(m_dv));
    chk("dout_even", 32'(dout_e), 32'(m_dout));
    chk("dout_odd", 32'(dout_o), 32'(m_dout));
    if (m_dv) begin
      chk("par_err_even", 32'(pe_e), 32'(m_pe_even));
      chk("par_err_odd", 32'(pe_o), 32'(!m_pe_even));
      chk("frm_err_even", 32'(fe_e), 32'(m_fe));
      chk("frm_err_odd", 32'(fe_o), 32'(m_fe));
    end
`ifdef PARCHK_ERRCNT_EN
    chk("err_cnt_even", 32'(ec_e), 32'(m_ec));
`endif
  endtask

  task automatic step(input logic en, input logic s, input logic r);
    bit_en = en;
    sin    = s;
    rst    = r;
    @(posedge clk);
    model_edge(en, s, r);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic p, input logic stop);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DW; i++) step(1'b1, data[i], 1'b0);
    step(1'b1, p, 1'b0);
    step(1'b1, stop, 1'b0);
  endtask

  task automatic sparse_bit(input logic s);
    for (int k = 0; k < 3; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b1, s, 1'b0);
  endtask

  initial begin
    tbl[0] = '{3'b101, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0};
    tbl[1] = '{3'b101, 1'b1, 1'b1, 3'b101, 1'b1, 1'b0};
    tbl[2] = '{3'b111, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1};
    for (int d = 0; d < 8; d++) begin
      logic [DW-1:0] dv;
      dv = d[DW-1:0];
      tbl[3 + d] = '{dv, ^dv, 1'b1, dv, 1'b0, 1'b0};
    end

    // Reset state, with bit_en high to show rst wins.
    step(1'b1, 1'b0, 1'b1);
    chk("rst_dout", 32'(dout_e), 32'h0);
    chk("rst_dvalid", 32'(dv_e), 32'h0);
    chk("rst_busy", 32'(bz_e), 32'h0);
    chk("rst_par_err", 32'(pe_e), 32'h0);
    chk("rst_frm_err", 32'(fe_e), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    chk("idle_stays", 32'(bz_e), 32'h0);

    // Table frames, back-to-back.
    for (int t = 0; t < 11; t++) begin
      send_frame(tbl[t].data, tbl[t].pbit, tbl[t].stop);
      chk("tbl_dvalid", 32'(dv_e), 32'h1);
      chk("tbl_dout", 32'(dout_e), 32'(tbl[t].exp_dout));
      chk("tbl_par_err", 32'(pe_e), 32'(tbl[t].exp_pe));
      chk("tbl_frm_err", 32'(fe_e), 32'(tbl[t].exp_fe));
      chk("tbl_par_err_odd", 32'(pe_o), 32'(!tbl[t].exp_pe));
`ifdef PARCHK_ERRCNT_EN
      if (t == 1) chk("tbl_err_cnt_one", 32'(ec_e), 32'h1);
`endif
    end

    // Bit enable only on every 4th cycle.
    sparse_bit(1'b0);
    sparse_bit(1'b1);
    sparse_bit(1'b0);
    sparse_bit(1'b1);
    sparse_bit(1'b0);
    sparse_bit(1'b1);
    chk("sparse_dvalid", 32'(dv_e), 32'h1);
    chk("sparse_dout", 32'(dout_e), 32'h5);
    chk("sparse_errs", 32'({pe_e, fe_e}), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    chk("sparse_pulse_end", 32'(dv_e), 32'h0);
    chk("sparse_dout_hold", 32'(dout_e), 32'h5);

    // Reset mid-frame, then a clean frame.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("abort_busy", 32'(bz_e), 32'h0);
    chk("abort_dvalid", 32'(dv_e), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("abort_no_pulse", 32'(dv_e), 32'h0);
    end
    send_frame(3'b010, 1'b1, 1'b1);
    chk("after_abort_dvalid", 32'(dv_e), 32'h1);
    chk("after_abort_dout", 32'(dout_e), 32'h2);
    chk("after_abort_errs", 32'({pe_e, fe_e}), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      step(1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parchk.md
PARCHK -- requirements
Module: parchk

Interface
REQ-001 Parameter DATA_W, default 3, SHALL set the data bits per frame; legal range 1..16.
REQ-002 Parameter ODD_PAR, default 0, SHALL select the parity sense: 0 = even parity, matching the team's parity generator; 1 = odd parity.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-005 Port bit_en, input, 1, SHALL qualify sin; a bit is consumed only on a clk edge where bit_en=1.
REQ-006 Port sin, input, 1, SHALL carry the serial frame.
REQ-007 Port dout, output, DATA_W, SHALL hold the data of the last completed frame.
REQ-008 Port dvalid, output, 1, SHALL pulse one cycle per completed frame.
REQ-009 Port par_err, output, 1, SHALL flag a parity mismatch; valid only while dvalid=1.
REQ-010 Port frm_err, output, 1, SHALL flag a bad stop bit; valid only while dvalid=1.
REQ-011 Port busy, output, 1, SHALL be 1 whenever the FSM is not in IDLE.

Function
REQ-012 Frame SHALL be, in consumption order:
- start bit (0)
- DATA_W data bits, LSB first
- one parity bit
- one stop bit (1)
REQ-013 FSM states SHALL be IDLE, DATA, PAR and STOP; cycles with bit_en=0 SHALL not change the state, bit count, shift register or parity accumulator.
REQ-014 IDLE SHALL move to DATA on a consumed sin=0; a consumed sin=1 SHALL remain in IDLE (line idle).
REQ-015 DATA SHALL shift each consumed bit into the MSB of the shift register and XOR it into the accumulator.
REQ-016 DATA SHALL move to PAR after exactly DATA_W consumed bits; the bit counter is clog2(DATA_W+1) wide and clears on entry to DATA.
REQ-017 PAR SHALL consume one bit and compute mismatch = acc ^ sin ^ ODD_PAR, then move to STOP.
REQ-018 STOP SHALL consume one bit and return to IDLE.
REQ-019 On the edge that consumes the stop bit, the block SHALL register all of the following for exactly one cycle: dout = shift register, dvalid = 1, par_err = mismatch, frm_err = (sin==0).
REQ-020 Latency SHALL be 1 clk from the stop-bit edge to dvalid visible.
REQ-021 dout SHALL hold its value until the next completed frame.
REQ-022 A frame with frm_err=1 SHALL still deliver dout; no resynchronisation or hunting logic beyond the IDLE start detection is required.
REQ-023 A start bit consumed on the cycle directly after dvalid SHALL be accepted, giving back-to-back frames with no idle bit required.

Reset
REQ-024 rst=1 SHALL force, at the next clk edge, the following values regardless of bit_en:
- state IDLE
- counter, shift register and accumulator 0
- dout 0
- dvalid, par_err, frm_err and busy 0
REQ-025 rst asserted mid-frame SHALL abandon the frame with no dvalid pulse; rst SHALL take priority over bit_en.

Configuration
REQ-026 Macro PARCHK_ERRCNT_EN defined: the block SHALL add output err_cnt, 8 bits, which increments on each dvalid with par_err or frm_err set, saturates at 255 and clears on rst.
REQ-027 Macro PARCHK_ERRCNT_EN undefined: the err_cnt port and the counter logic SHALL be absent, with all other behaviour identical.

Structure
REQ-028 A shared package parchk_pkg SHALL hold the FSM state enum (IDLE, DATA, PAR, STOP) and the constants START_BIT=0, STOP_BIT=1 and ERRCNT_W=8.
REQ-029 The design SHALL be a single module, except that the saturating error counter SHALL be the sub-module parchk_errcnt, instantiated only when PARCHK_ERRCNT_EN is defined.

Verification
REQ-030 Scenario (DATA_W=3, even parity, bit_en=1 every cycle): sin 0,1,0,1,0,1 -> dout=3'b101, dvalid pulse, par_err=0, frm_err=0.
REQ-031 Scenario: same frame with parity bit 1 -> dvalid with par_err=1, frm_err=0; err_cnt=1 if PARCHK_ERRCNT_EN is defined.
REQ-032 Scenario: frame 0,1,1,1,1,0 (stop bit 0) -> dout=3'b111, par_err=0, frm_err=1.
REQ-033 Scenario: valid frame with bit_en=1 only on every 4th cycle -> same result as REQ-030, with dvalid 1 cycle after the 6th enabled edge.
REQ-034 Scenario: rst pulsed after the 3rd bit of a frame, then a full valid frame of data 3'b010 -> no pulse for the aborted frame, then dout=3'b010 with no errors.
REQ-035 Scenario: exhaustive loop over all 8 data values with correct parity and frames back-to-back -> 8 dvalid pulses with no errors; with ODD_PAR=1 and even-parity bits -> par_err=1 on all 8.
